id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of instr-derived data, pc and operands.
REQ-002 Parameter FWD_PORTS, default 2, number of forwarding sources; index 0 = youngest (EX), higher = older (MEM, WB).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  IF offers instr/pc; in_ready  output  1  stage accepts this cycle.
REQ-006 instr_i  input  32  instruction word; pc_i  input  XLEN  its address.
REQ-007 gprs_raddr1/gprs_raddr2  output  5  combinational GPR read addresses = rs1/rs2 of instr_i; gprs_rdata1_i/gprs_rdata2_i  input  XLEN  asynchronous read data.
REQ-008 fwd_valid  input  FWD_PORTS; fwd_waddr  input  5*FWD_PORTS; fwd_wdata  input  XLEN*FWD_PORTS  forwarding sources.
REQ-009 ex_load_valid  input  1, ex_load_rd  input  5  instruction in EX is a load targeting ex_load_rd.
REQ-010 flush_i  input  1  branch/exception redirect; kills the registered and incoming instruction.
REQ-011 out_valid  output  1, out_ready  input  1  handshake to ID_EX consumer.
REQ-012 out_rtlop  output  RTLOP width, out_rtltype  output  RTLTYPE width, out_pc/out_src1/out_src2  output  XLEN, out_waddr  output  5, out_illegal  output  1  registered decoded payload.
REQ-013 error_o  output  1  sticky illegal-instruction flag to cpu_ctrl.

Function
REQ-014 Stage SHALL hold one registered output slot; transfer in on in_valid&&in_ready, out on out_valid&&out_ready.
REQ-015 in_ready SHALL = (!out_valid || out_ready) && !hazard && !flush_i.
REQ-016 hazard SHALL = ex_load_valid && ex_load_rd!=0 && ((rs1 used && rs1==ex_load_rd) || (rs2 used && rs2==ex_load_rd)); rs2 used only for OP.
REQ-017 On hazard with out slot drained (out_ready or !out_valid), slot SHALL load a bubble (out_valid=0) next cycle; instr_i held by IF.
REQ-018 Operand SHALL take fwd_wdata of lowest index i with fwd_valid[i] && fwd_waddr[i]==rs && rs!=0, else gprs_rdata; x0 reads always 0.
REQ-019 Decode: OP-IMM -> src2=sign-ext I-imm, rtlop={0,funct3}, SRLI/SRAI select SHR/SAR by funct7, other funct7 on shift illegal.
REQ-020 Decode: OP -> ADD/SUB via funct7 (SUB: src2 = two's complement, XLEN wrap), SRL/SRA by funct7, others need funct7=0 else illegal.
REQ-021 Decode: LUI -> src1=0, src2={imm[31:12],12'b0} sign-extended to XLEN, ADD; AUIPC -> src1=pc_i, same src2, ADD.
REQ-022 Any other opcode, or low two bits != 2'b11, SHALL set out_illegal=1 with out_waddr=0.
REQ-023 Legal instructions SHALL set out_waddr=rd; rtltype=ARICH for all supported groups.
REQ-024 Latency SHALL be exactly 1 cycle from accept to out_valid when out_ready held high.
REQ-025 Output payload SHALL remain stable while out_valid && !out_ready.
REQ-026 flush_i SHALL clear out_valid next edge and accept nothing; flush wins over hazard and stall.
REQ-027 error_o SHALL set on the edge where an out_illegal instruction transfers out, and hold until reset.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_illegal=0, error_o=0, out_waddr=0, out_rtlop=ADD, out_rtltype=ARICH, out_pc/out_src1/out_src2=0.
REQ-029 Reset mid-stall or mid-backpressure SHALL discard the held instruction; first accept possible the cycle after rst_n deasserts.

Structure
REQ-030 RTLOP_*/RTLTYPE_* encodings, INSTRGROUP_* opcodes, FUNCT3_*/FUNCT7_* and REG_X0 SHALL live in the shared common definitions, not in the module.
REQ-031 Combinational decode SHALL be a sub-module id_decode (instr, pc, operands -> payload, illegal); id_stage holds forwarding, hazard, handshake and register.

Verification
REQ-032 ADDI x1,x0,5 then ADD x2,x1,x1 with fwd port0 {x1,5}: out_src1=out_src2=5, out_waddr=2, one result per cycle.
REQ-033 Port0 {x3,7} and port1 {x3,9} both valid: src1 of rs1=x3 = 7; with port0 invalid = 9; rs1=x0 with port {x0,1} = 0.
REQ-034 ex_load_valid, ex_load_rd=4, ADD x5,x4,x6: in_ready=0 one cycle, bubble out, then accept with forwarded value.
REQ-035 out_ready low 3 cycles holding SUB x1,x2,x3 (x2=1,x3=2): payload stable, src2=0xFFFFFFFE, in_ready=0.
REQ-036 opcode 7'b1100011 accepted: out_illegal=1, out_waddr=0, error_o rises on transfer and stays 1; flush_i same cycle as in_valid: nothing emitted.
REQ-037 rst_n pulsed low while out_valid=1: out_valid and error_o drop asynchronously; LUI x7,0x12345 after reset: src2=0x12345000.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared encodings for the decode stage: RTL op/type codes, RISC-V opcode groups,
// funct fields and operand-usage helpers.
package id_stage_pkg;

  localparam int RTLOP_W   = 4;
  localparam int RTLTYPE_W = 2;

  // Low three bits mirror funct3 so OP/OP-IMM can pass funct3 straight through.
  typedef enum logic [RTLOP_W-1:0] {
    RTLOP_ADD  = 4'h0,
    RTLOP_SLL  = 4'h1,
    RTLOP_SLT  = 4'h2,
    RTLOP_SLTU = 4'h3,
    RTLOP_XOR  = 4'h4,
    RTLOP_SHR  = 4'h5,
    RTLOP_OR   = 4'h6,
    RTLOP_AND  = 4'h7,
    RTLOP_SAR  = 4'hD
  } rtlop_e;

  typedef enum logic [RTLTYPE_W-1:0] {
    RTLTYPE_ARICH = 2'd0,
    RTLTYPE_MEM   = 2'd1,
    RTLTYPE_CTRL  = 2'd2
  } rtltype_e;

  localparam logic [6:0] INSTRGROUP_OP_IMM = 7'b0010011;
  localparam logic [6:0] INSTRGROUP_OP     = 7'b0110011;
  localparam logic [6:0] INSTRGROUP_LUI    = 7'b0110111;
  localparam logic [6:0] INSTRGROUP_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == INSTRGROUP_OP_IMM) || (opcode == INSTRGROUP_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == INSTRGROUP_OP);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decode: turns an instruction, its pc and resolved
// operands into the ID/EX payload plus an illegal flag.
module id_decode
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  output logic [RTLOP_W-1:0]   rtlop_o,
  output logic [RTLTYPE_W-1:0] rtltype_o,
  output logic [XLEN-1:0]      src1_o,
  output logic [XLEN-1:0]      src2_o,
  output logic [4:0]           waddr_o,
  output logic                 illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic signed [XLEN-1:0] imm_i_s;
  logic signed [XLEN-1:0] imm_u_s;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign imm_i_s = XLEN'($signed(instr_i[31:20]));
  assign imm_u_s = XLEN'($signed({instr_i[31:12], 12'b0}));

  always_comb begin
    rtlop_o   = RTLOP_ADD;
    rtltype_o = RTLTYPE_ARICH;
    src1_o    = '0;
    src2_o    = '0;
    waddr_o   = '0;
    illegal_o = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opcode)
        INSTRGROUP_OP_IMM: begin
          src1_o  = rs1_data_i;
          src2_o  = imm_i_s;
          rtlop_o = {1'b0, funct3};
          if (funct3 == FUNCT3_SLL) begin
            if (funct7 != FUNCT7_ZERO) illegal_o = 1'b1;
          end else if (funct3 == FUNCT3_SRL_SRA) begin
            if (funct7 == FUNCT7_ALT)       rtlop_o   = RTLOP_SAR;
            else if (funct7 != FUNCT7_ZERO) illegal_o = 1'b1;
          end
        end
        INSTRGROUP_OP: begin
          src1_o  = rs1_data_i;
          src2_o  = rs2_data_i;
          rtlop_o = {1'b0, funct3};
          case (funct3)
            // SUB is issued as ADD of the negated operand.
            FUNCT3_ADD_SUB: begin
              if (funct7 == FUNCT7_ALT)       src2_o    = {XLEN{1'b0}} - rs2_data_i;
              else if (funct7 != FUNCT7_ZERO) illegal_o = 1'b1;
            end
            FUNCT3_SRL_SRA: begin
              if (funct7 == FUNCT7_ALT)       rtlop_o   = RTLOP_SAR;
              else if (funct7 != FUNCT7_ZERO) illegal_o = 1'b1;
            end
            default: begin
              if (funct7 != FUNCT7_ZERO) illegal_o = 1'b1;
            end
          endcase
        end
        INSTRGROUP_LUI: begin
          src1_o = '0;
          src2_o = imm_u_s;
        end
        INSTRGROUP_AUIPC: begin
          src1_o = pc_i;
          src2_o = imm_u_s;
        end
        default: illegal_o = 1'b1;
      endcase
    end

    if (illegal_o) begin
      rtlop_o = RTLOP_ADD;
      src1_o  = '0;
      src2_o  = '0;
      waddr_o = '0;
    end else begin
      waddr_o = rd;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: operand forwarding, load-use hazard detection, valid/ready
// handshake and the single registered ID/EX output slot.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instr_i,
  input  logic [XLEN-1:0]           pc_i,
  output logic [4:0]                gprs_raddr1,
  output logic [4:0]                gprs_raddr2,
  input  logic [XLEN-1:0]           gprs_rdata1_i,
  input  logic [XLEN-1:0]           gprs_rdata2_i,
  input  logic [FWD_PORTS-1:0]      fwd_valid,
  input  logic [5*FWD_PORTS-1:0]    fwd_waddr,
  input  logic [XLEN*FWD_PORTS-1:0] fwd_wdata,
  input  logic                      ex_load_valid,
  input  logic [4:0]                ex_load_rd,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RTLOP_W-1:0]        out_rtlop,
  output logic [RTLTYPE_W-1:0]      out_rtltype,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_src1,
  output logic [XLEN-1:0]           out_src2,
  output logic [4:0]                out_waddr,
  output logic                      out_illegal,
  output logic                      error_o
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] op1, op2;
  logic            hazard, slot_free, accept;

  logic [RTLOP_W-1:0]   dec_rtlop;
  logic [RTLTYPE_W-1:0] dec_rtltype;
  logic [XLEN-1:0]      dec_src1, dec_src2;
  logic [4:0]           dec_waddr;
  logic                 dec_illegal;

  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 illegal_q, illegal_d;
  logic [RTLOP_W-1:0]   rtlop_q, rtlop_d;
  logic [RTLTYPE_W-1:0] rtltype_q, rtltype_d;
  logic [XLEN-1:0]      pc_q, pc_d, src1_q, src1_d, src2_q, src2_d;
  logic [4:0]           waddr_q, waddr_d;

  assign opcode      = instr_i[6:0];
  assign rs1         = instr_i[19:15];
  assign rs2         = instr_i[24:20];
  assign gprs_raddr1 = rs1;
  assign gprs_raddr2 = rs2;

  // Walk from oldest to youngest so the lowest-index (youngest) match wins.
  always_comb begin
    op1 = (rs1 == REG_X0) ? '0 : gprs_rdata1_i;
    op2 = (rs2 == REG_X0) ? '0 : gprs_rdata2_i;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_waddr[i*5 +: 5] == rs1 && rs1 != REG_X0)
        op1 = fwd_wdata[i*XLEN +: XLEN];
      if (fwd_valid[i] && fwd_waddr[i*5 +: 5] == rs2 && rs2 != REG_X0)
        op2 = fwd_wdata[i*XLEN +: XLEN];
    end
  end

  assign hazard = ex_load_valid && (ex_load_rd != REG_X0) &&
                  ((uses_rs1(opcode) && rs1 == ex_load_rd) ||
                   (uses_rs2(opcode) && rs2 == ex_load_rd));

  assign slot_free = !valid_q || out_ready;
  assign in_ready  = slot_free && !hazard && !flush_i;
  assign accept    = in_valid && in_ready;

  id_decode #(.XLEN(XLEN)) u_decode (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (op1),
    .rs2_data_i (op2),
    .rtlop_o    (dec_rtlop),
    .rtltype_o  (dec_rtltype),
    .src1_o     (dec_src1),
    .src2_o     (dec_src2),
    .waddr_o    (dec_waddr),
    .illegal_o  (dec_illegal)
  );

  // A drained slot with nothing accepted becomes a bubble; payload only moves on accept.
  always_comb begin
    valid_d   = valid_q;
    error_d   = error_q || (valid_q && out_ready && illegal_q);
    illegal_d = illegal_q;
    rtlop_d   = rtlop_q;
    rtltype_d = rtltype_q;
    pc_d      = pc_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    waddr_d   = waddr_q;
    if (flush_i)        valid_d = 1'b0;
    else if (slot_free) valid_d = accept;
    if (accept) begin
      illegal_d = dec_illegal;
      rtlop_d   = dec_rtlop;
      rtltype_d = dec_rtltype;
      pc_d      = pc_i;
      src1_d    = dec_src1;
      src2_d    = dec_src2;
      waddr_d   = dec_waddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      illegal_q <= 1'b0;
      rtlop_q   <= RTLOP_ADD;
      rtltype_q <= RTLTYPE_ARICH;
      pc_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      waddr_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      error_q   <= error_d;
      illegal_q <= illegal_d;
      rtlop_q   <= rtlop_d;
      rtltype_q <= rtltype_d;
      pc_q      <= pc_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      waddr_q   <= waddr_d;
    end
  end

  assign out_valid   = valid_q;
  assign error_o     = error_q;
  assign out_illegal = illegal_q;
  assign out_rtlop   = rtlop_q;
  assign out_rtltype = rtltype_q;
  assign out_pc      = pc_q;
  assign out_src1    = src1_q;
  assign out_src2    = src2_q;
  assign out_waddr   = waddr_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: forwarding, hazards, backpressure, decode,
// illegal/flush handling and asynchronous reset.
module tb_id_stage;

  localparam int XLEN = 32;
  localparam int FP   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic [4:0]      gprs_raddr1, gprs_raddr2;
  logic [XLEN-1:0] gprs_rdata1_i, gprs_rdata2_i;
  logic [FP-1:0]   fwd_valid;
  logic [5*FP-1:0] fwd_waddr;
  logic [XLEN*FP-1:0] fwd_wdata;
  logic            ex_load_valid;
  logic [4:0]      ex_load_rd;
  logic            flush_i;
  logic            out_valid, out_ready;
  logic [3:0]      out_rtlop;
  logic [1:0]      out_rtltype;
  logic [XLEN-1:0] out_pc, out_src1, out_src2;
  logic [4:0]      out_waddr;
  logic            out_illegal, error_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign gprs_rdata1_i = rf[gprs_raddr1];
  assign gprs_rdata2_i = rf[gprs_raddr2];

  id_stage #(.XLEN(XLEN), .FWD_PORTS(FP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .gprs_raddr1(gprs_raddr1), .gprs_raddr2(gprs_raddr2),
    .gprs_rdata1_i(gprs_rdata1_i), .gprs_rdata2_i(gprs_rdata2_i),
    .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_rtlop(out_rtlop),
    .out_rtltype(out_rtltype), .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2),
    .out_waddr(out_waddr), .out_illegal(out_illegal), .error_o(error_o)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int p, input logic v, input logic [4:0] a, input logic [31:0] d);
    fwd_valid[p]       = v;
    fwd_waddr[p*5 +: 5] = a;
    fwd_wdata[p*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; instr_i = '0; pc_i = '0; fwd_valid = '0; fwd_waddr = '0;
    fwd_wdata = '0; ex_load_valid = 1'b0; ex_load_rd = '0; flush_i = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error_o); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", out_illegal); end
    checks++; if ({out_waddr, out_rtlop, out_rtltype} !== 11'd0) begin failures++;
      $display("FAIL reset_ctl got=%h/%h/%h exp=0/0/0", out_waddr, out_rtlop, out_rtltype); end
    checks++; if ({out_pc, out_src1, out_src2} !== 96'd0) begin failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", out_pc, out_src1, out_src2); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fwd_chain();
    in_valid = 1'b1; pc_i = 32'h100; instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    step();
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'd0 || out_src2 !== 32'd5 || out_waddr !== 5'd1)
      begin failures++; $display("FAIL chain_addi got=%b/%h/%h/%0d exp=1/0/5/1", out_valid, out_src1, out_src2, out_waddr); end
    checks++; if (out_pc !== 32'h100 || out_rtlop !== 4'h0) begin failures++;
      $display("FAIL chain_addi_pc got=%h/%h exp=100/0", out_pc, out_rtlop); end
    pc_i = 32'h104; instr_i = enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2);
    set_fwd(0, 1'b1, 5'd1, 32'd5);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL chain_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'd5 || out_src2 !== 32'd5 || out_waddr !== 5'd2)
      begin failures++; $display("FAIL chain_add got=%b/%h/%h/%0d exp=1/5/5/2", out_valid, out_src1, out_src2, out_waddr); end
    in_valid = 1'b0; set_fwd(0, 1'b0, 5'd0, 32'd0);
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL chain_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_fwd_priority();
    in_valid = 1'b1; instr_i = enc_i(12'd0, 5'd3, 3'd0, 5'd10);
    set_fwd(0, 1'b1, 5'd3, 32'd7); set_fwd(1, 1'b1, 5'd3, 32'd9);
    step();
    checks++; if (out_src1 !== 32'd7) begin failures++; $display("FAIL fwd_port0 got=%h exp=7", out_src1); end
    set_fwd(0, 1'b0, 5'd3, 32'd7);
    step();
    checks++; if (out_src1 !== 32'd9) begin failures++; $display("FAIL fwd_port1 got=%h exp=9", out_src1); end
    set_fwd(1, 1'b0, 5'd3, 32'd9);
    step();
    checks++; if (out_src1 !== 32'd2) begin failures++; $display("FAIL fwd_gpr got=%h exp=2", out_src1); end
    instr_i = enc_i(12'd0, 5'd0, 3'd0, 5'd10); set_fwd(0, 1'b1, 5'd0, 32'd1);
    step();
    checks++; if (out_src1 !== 32'd0) begin failures++; $display("FAIL fwd_x0 got=%h exp=0", out_src1); end
    set_fwd(0, 1'b0, 5'd0, 32'd0); in_valid = 1'b0;
    step();
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; instr_i = enc_i(12'd3, 5'd0, 3'd0, 5'd9);
    step();
    checks++; if (out_valid !== 1'b1 || out_waddr !== 5'd9) begin failures++;
      $display("FAIL haz_pre got=%b/%0d exp=1/9", out_valid, out_waddr); end
    instr_i = enc_r(7'd0, 5'd6, 5'd4, 3'd0, 5'd5); ex_load_valid = 1'b1; ex_load_rd = 5'd4;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_in_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL haz_bubble got=%b exp=0", out_valid); end
    ex_load_valid = 1'b0; set_fwd(1, 1'b1, 5'd4, 32'h44);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_release got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h44 || out_src2 !== 32'd5 || out_waddr !== 5'd5)
      begin failures++; $display("FAIL haz_accept got=%b/%h/%h/%0d exp=1/44/5/5", out_valid, out_src1, out_src2, out_waddr); end
    set_fwd(1, 1'b0, 5'd0, 32'd0);
    instr_i = enc_i(12'd4, 5'd1, 3'd0, 5'd5); ex_load_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_imm_rs2 got=%b exp=1", in_ready); end
    instr_i = enc_r(7'd0, 5'd4, 5'd6, 3'd0, 5'd5);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_op_rs2 got=%b exp=0", in_ready); end
    ex_load_rd = 5'd0; instr_i = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd5);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_x0 got=%b exp=1", in_ready); end
    ex_load_valid = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; instr_i = enc_r(7'b0100000, 5'd3, 5'd2, 3'd0, 5'd1);
    step();
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'd1 || out_src2 !== 32'hFFFFFFFE || out_rtlop !== 4'h0)
      begin failures++; $display("FAIL bp_sub got=%b/%h/%h/%h exp=1/1/fffffffe/0", out_valid, out_src1, out_src2, out_rtlop); end
    out_ready = 1'b0; instr_i = enc_i(12'd9, 5'd0, 3'd0, 5'd8);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_src2 !== 32'hFFFFFFFE || out_waddr !== 5'd1 || out_src1 !== 32'd1)
        begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/fffffffe/1", k, out_valid, out_src2, out_waddr); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    step();
    checks++; if (out_waddr !== 5'd8 || out_src2 !== 32'd9) begin failures++;
      $display("FAIL bp_next got=%0d/%h exp=8/9", out_waddr, out_src2); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal_flush();
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL ill_pre_error got=%b exp=0", error_o); end
    in_valid = 1'b1; instr_i = 32'h000003E3;
    step();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_waddr !== 5'd0)
      begin failures++; $display("FAIL ill_branch got=%b/%b/%0d exp=1/1/0", out_valid, out_illegal, out_waddr); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL ill_error_early got=%b exp=0", error_o); end
    instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd3) & ~32'h2;
    step();
    checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL ill_error_rise got=%b exp=1", error_o); end
    checks++; if (out_illegal !== 1'b1 || out_waddr !== 5'd0) begin failures++;
      $display("FAIL ill_lowbits got=%b/%0d exp=1/0", out_illegal, out_waddr); end
    in_valid = 1'b0;
    step(); step();
    checks++; if (error_o !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL ill_sticky got=%b/%b exp=1/0", error_o, out_valid); end
    in_valid = 1'b1; instr_i = enc_i(12'd1, 5'd0, 3'd0, 5'd3); flush_i = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_incoming got=%b exp=0", out_valid); end
    flush_i = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_waddr !== 5'd3) begin failures++;
      $display("FAIL flush_refill got=%b/%0d exp=1/3", out_valid, out_waddr); end
    in_valid = 1'b0; out_ready = 1'b0; flush_i = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_slot got=%b exp=0", out_valid); end
    flush_i = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_decode();
    in_valid = 1'b1; instr_i = {7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1, 7'b0010011};
    step();
    checks++; if (out_rtlop !== 4'hD || out_src1 !== 32'd1 || out_src2 !== 32'h403 || out_illegal !== 1'b0)
      begin failures++; $display("FAIL dec_srai got=%h/%h/%h/%b exp=d/1/403/0", out_rtlop, out_src1, out_src2, out_illegal); end
    instr_i = enc_i(12'hFFF, 5'd2, 3'd0, 5'd4);
    step();
    checks++; if (out_src2 !== 32'hFFFFFFFF || out_waddr !== 5'd4) begin failures++;
      $display("FAIL dec_addi_neg got=%h/%0d exp=ffffffff/4", out_src2, out_waddr); end
    instr_i = enc_r(7'd0, 5'd3, 5'd2, 3'b100, 5'd6);
    step();
    checks++; if (out_rtlop !== 4'h4 || out_src2 !== 32'd2 || out_rtltype !== 2'd0) begin failures++;
      $display("FAIL dec_xor got=%h/%h/%h exp=4/2/0", out_rtlop, out_src2, out_rtltype); end
    instr_i = enc_r(7'b0100000, 5'd3, 5'd2, 3'b101, 5'd6);
    step();
    checks++; if (out_rtlop !== 4'hD || out_illegal !== 1'b0) begin failures++;
      $display("FAIL dec_sra got=%h/%b exp=d/0", out_rtlop, out_illegal); end
    instr_i = {7'b0100000, 5'd1, 5'd2, 3'b001, 5'd7, 7'b0010011};
    step();
    checks++; if (out_illegal !== 1'b1 || out_waddr !== 5'd0) begin failures++;
      $display("FAIL dec_slli_f7 got=%b/%0d exp=1/0", out_illegal, out_waddr); end
    instr_i = enc_r(7'd1, 5'd3, 5'd2, 3'b110, 5'd7);
    step();
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL dec_or_f7 got=%b exp=1", out_illegal); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; instr_i = enc_i(12'd1, 5'd0, 3'd0, 5'd2);
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || error_o !== 1'b1) begin failures++;
      $display("FAIL ar_pre got=%b/%b exp=1/1", out_valid, error_o); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || error_o !== 1'b0) begin failures++;
      $display("FAIL ar_drop got=%b/%b exp=0/0", out_valid, error_o); end
    checks++; if (out_src2 !== 32'd0 || out_waddr !== 5'd0) begin failures++;
      $display("FAIL ar_payload got=%h/%0d exp=0/0", out_src2, out_waddr); end
    step();
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    instr_i = enc_u(20'h12345, 5'd7, 7'b0110111);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src1 !== 32'd0 || out_src2 !== 32'h12345000 || out_waddr !== 5'd7)
      begin failures++; $display("FAIL ar_lui got=%b/%h/%h/%0d exp=1/0/12345000/7", out_valid, out_src1, out_src2, out_waddr); end
    pc_i = 32'h1000; instr_i = enc_u(20'h80000, 5'd8, 7'b0010111);
    step();
    checks++; if (out_src1 !== 32'h1000 || out_src2 !== 32'h80000000 || out_waddr !== 5'd8)
      begin failures++; $display("FAIL ar_auipc got=%h/%h/%0d exp=1000/80000000/8", out_src1, out_src2, out_waddr); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || error_o !== 1'b0) begin failures++;
      $display("FAIL ar_end got=%b/%b exp=0/0", out_valid, error_o); end
  endtask

  initial begin
    rf[0] = 32'hDEADBEEF;
    for (int r = 1; r < 32; r++) rf[r] = r - 1;
    test_reset();
    test_fwd_chain();
    test_fwd_priority();
    test_hazard();
    test_backpressure();
    test_illegal_flush();
    test_decode();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
